// File: rtl/base_components_pkg.sv
// Shared definitions for the base_components serial blocks: FSM state encoding
// and the bit-counter width helper.
package base_components_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } pisoState_t;

    // One spare code above the longest frame (data plus optional parity bit).
    function automatic int countWidth(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Enabled up-counter with synchronous clear and load. It stops at LAST, never
// wraps, and flags LAST on tcOut.
module piso_bit_counter
    import base_components_pkg::*;
#(
    parameter int COUNT_W = 4,
    parameter int LAST    = 7
) (
    input  logic               clkIn,
    input  logic               rstIn,
    input  logic               enIn,
    input  logic               clrIn,
    input  logic               loadIn,
    input  logic [COUNT_W-1:0] loadValIn,
    output logic [COUNT_W-1:0] countOut,
    output logic               tcOut
);

    logic [COUNT_W-1:0] count;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            count <= '0;
        end else if (enIn) begin
            if (clrIn)
                count <= '0;
            else if (loadIn)
                count <= loadValIn;
            else if (count != COUNT_W'(LAST))
                count <= count + COUNT_W'(1);
        end
    end

    assign countOut = count;
    assign tcOut    = (count == COUNT_W'(LAST));

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter with valid/ready load and true/complement serial
// outputs. Define PISO_PARITY_EN to append an even-parity bit to every word.
module piso_shifter
    import base_components_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic             enIn,
    input  logic             loadValidIn,
    output logic             loadReadyOut,
    input  logic [WIDTH-1:0] dataIn,
    output logic             serialOut,
    output logic             serialNotOut,
    output logic             validOut,
    output logic             lastOut,
    output logic             busyOut
);

    localparam int COUNT_W = countWidth(WIDTH);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    pisoState_t         state;
    pisoState_t         stateNext;
    logic [WIDTH-1:0]   shiftReg;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] nextIdx;
    logic               termCount;
    logic               lastBit;
    logic               accept;
    logic               nextBit;
    logic               serialReg;
    logic               serialNotReg;

    // Bit of word w that goes out in frame position idx (data positions only).
    function automatic logic bitAt(input logic [WIDTH-1:0] w, input logic [COUNT_W-1:0] idx);
        logic [WIDTH-1:0] moved;
        if (MSB_FIRST) begin
            moved = w << idx;
            return moved[WIDTH-1];
        end else begin
            moved = w >> idx;
            return moved[0];
        end
    endfunction

    assign lastBit      = (state == ST_SHIFT) && termCount;
    assign loadReadyOut = enIn && ((state == ST_IDLE) || lastBit);
    assign accept       = loadValidIn && loadReadyOut;
    assign nextIdx      = count + COUNT_W'(1);

    piso_bit_counter #(
        .COUNT_W (COUNT_W),
        .LAST    (FRAME_LEN - 1)
    ) bitCounter (
        .clkIn     (clkIn),
        .rstIn     (rstIn),
        .enIn      (enIn),
        .clrIn     (stateNext == ST_IDLE),
        .loadIn    (accept),
        .loadValIn ('0),
        .countOut  (count),
        .tcOut     (termCount)
    );

    always_ff @(posedge clkIn) begin
        if (rstIn)
            state <= ST_IDLE;
        else if (enIn)
            state <= stateNext;
    end

    // A load on the last bit chains straight into the next word with no gap.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  if (accept) stateNext = ST_SHIFT;
            ST_SHIFT: if (lastBit && !accept) stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        nextBit = IDLE_LEVEL;
        if (accept) begin
            nextBit = bitAt(dataIn, '0);
        end else if ((state == ST_SHIFT) && !lastBit) begin
`ifdef PISO_PARITY_EN
            if (nextIdx == COUNT_W'(WIDTH))
                nextBit = ^shiftReg;
            else
                nextBit = bitAt(shiftReg, nextIdx);
`else
            nextBit = bitAt(shiftReg, nextIdx);
`endif
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            shiftReg     <= '0;
            serialReg    <= IDLE_LEVEL;
            serialNotReg <= ~IDLE_LEVEL;
        end else if (enIn) begin
            if (accept)
                shiftReg <= dataIn;
            serialReg    <= nextBit;
            serialNotReg <= ~nextBit;
        end
    end

    assign serialOut    = serialReg;
    assign serialNotOut = serialNotReg;
    assign validOut     = (state == ST_SHIFT);
    assign busyOut      = (state == ST_SHIFT);
    assign lastOut      = lastBit;

endmodule
